// File: rtl/mode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mode_sequencer_if
// Description : Front-panel bus bundling the raw buttons, the counter data
//               words and the sequencer's strobes and display outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface mode_sequencer_if;
    logic [3:0]  button;
    logic        sec_tick;
    logic [23:0] clock_data;
    logic [23:0] timer_data;
    logic [23:0] alarm_data;
    logic [23:0] stopwatch_data;
    logic [1:0]  rezhim;
    logic [1:0]  setup_field;
    logic        inc_pulse;
    logic        start_stop;
    logic        setup_commit;
    logic [23:0] display_data;
    logic [2:0]  blank_mask;

    modport master (
        output button, sec_tick, clock_data, timer_data, alarm_data, stopwatch_data,
        input  rezhim, setup_field, inc_pulse, start_stop, setup_commit,
               display_data, blank_mask
    );

    modport slave (
        input  button, sec_tick, clock_data, timer_data, alarm_data, stopwatch_data,
        output rezhim, setup_field, inc_pulse, start_stop, setup_commit,
               display_data, blank_mask
    );
endinterface
`default_nettype wire

// File: rtl/mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mode_sequencer
// Description : Debounces the four panel buttons, runs the mode/setup FSM,
//               issues counter strobes and drives the blinking display mux.
// Revision    : 1.0 - initial release
// ============================================================================
module mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_HALF      = 25000000,
    parameter int IDLE_TIMEOUT    = 30
) (
    input  wire logic       clock,
    input  wire logic       reset,
    mode_sequencer_if.slave bus
);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_HALF + 1);
    localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [IDL_W-1:0] IDL_LAST = IDL_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        SETUP_SEC  = 2'd1,
        SETUP_MIN  = 2'd2,
        SETUP_HOUR = 2'd3
    } state_t;

    logic [3:0] press;

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic             sync_a;
        logic             sync_b;
        logic             level;
        logic             pulse;
        logic [DEB_W-1:0] count;

        // Level flips only after the sample has disagreed for DEBOUNCE_CYCLES+1 edges.
        always_ff @(posedge clock) begin
            if (!reset) begin
                sync_a <= 1'b0;
                sync_b <= 1'b0;
                level  <= 1'b0;
                pulse  <= 1'b0;
                count  <= '0;
            end else begin
                sync_a <= bus.button[i];
                sync_b <= sync_a;
                pulse  <= 1'b0;
                if (sync_b == level) begin
                    count <= '0;
                end else if (count == DEB_MAX) begin
                    level <= sync_b;
                    pulse <= sync_b;
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end

        assign press[i] = pulse;
    end

    logic win_setup, win_start, win_inc, win_mode;
    assign win_setup = press[2];
    assign win_start = press[3] & ~press[2];
    assign win_inc   = press[1] & ~press[2] & ~press[3];
    assign win_mode  = press[0] & ~press[1] & ~press[2] & ~press[3];

    state_t           state, state_n;
    logic [1:0]       rezhim, rezhim_n;
    logic [IDL_W-1:0] idle_cnt, idle_n;
    logic [BLK_W-1:0] blink_cnt, blink_n;
    logic             phase, phase_n;
    logic             inc_pulse, inc_n;
    logic             start_stop, ss_n;
    logic             setup_commit, commit_n;
    logic             field_chg;
    logic [23:0]      display_data, display_n;
    logic [2:0]       blank_mask;

    always_comb begin
        state_n   = state;
        rezhim_n  = rezhim;
        idle_n    = idle_cnt;
        inc_n     = 1'b0;
        ss_n      = 1'b0;
        commit_n  = 1'b0;
        field_chg = 1'b0;
        case (state)
            NORMAL: begin
                idle_n = '0;
                if (win_mode) begin
                    rezhim_n = rezhim + 2'd1;
                end else if (win_setup && rezhim != 2'd3) begin
                    state_n   = SETUP_SEC;
                    field_chg = 1'b1;
                end else if (win_start && rezhim[0]) begin
                    ss_n = 1'b1;
                end
            end
            default: begin
                // Mode presses are ignored here and do not count as activity.
                if (win_setup) begin
                    field_chg = 1'b1;
                    idle_n    = '0;
                    case (state)
                        SETUP_SEC: state_n = SETUP_MIN;
                        SETUP_MIN: state_n = SETUP_HOUR;
                        default: begin
                            state_n  = NORMAL;
                            commit_n = 1'b1;
                        end
                    endcase
                end else if (win_start) begin
                    state_n   = NORMAL;
                    commit_n  = 1'b1;
                    field_chg = 1'b1;
                    idle_n    = '0;
                end else if (win_inc) begin
                    inc_n  = 1'b1;
                    idle_n = '0;
                end else if (bus.sec_tick) begin
                    if (idle_cnt == IDL_LAST) begin
                        state_n   = NORMAL;
                        field_chg = 1'b1;
                        idle_n    = '0;
                    end else begin
                        idle_n = idle_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    // Editing activity restarts the blink with the field visible.
    always_comb begin
        blink_n = blink_cnt;
        phase_n = phase;
        if (state_n == NORMAL || field_chg || inc_n) begin
            blink_n = '0;
            phase_n = 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_n = '0;
            phase_n = ~phase;
        end else begin
            blink_n = blink_cnt + 1'b1;
        end
    end

    always_comb begin
        display_n = display_data;
        case (rezhim)
            2'd0:    display_n = bus.clock_data;
            2'd1:    display_n = bus.timer_data;
            2'd2:    display_n = bus.alarm_data;
            default: display_n = bus.stopwatch_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= NORMAL;
            rezhim       <= 2'd0;
            idle_cnt     <= '0;
            blink_cnt    <= '0;
            phase        <= 1'b0;
            inc_pulse    <= 1'b0;
            start_stop   <= 1'b0;
            setup_commit <= 1'b0;
            display_data <= 24'd0;
        end else begin
            state        <= state_n;
            rezhim       <= rezhim_n;
            idle_cnt     <= idle_n;
            blink_cnt    <= blink_n;
            phase        <= phase_n;
            inc_pulse    <= inc_n;
            start_stop   <= ss_n;
            setup_commit <= commit_n;
            display_data <= display_n;
        end
    end

    always_comb begin
        blank_mask = 3'b000;
        case (state)
            SETUP_SEC:  blank_mask[0] = phase;
            SETUP_MIN:  blank_mask[1] = phase;
            SETUP_HOUR: blank_mask[2] = phase;
            default:    blank_mask    = 3'b000;
        endcase
    end

    assign bus.rezhim       = rezhim;
    assign bus.setup_field  = state;
    assign bus.inc_pulse    = inc_pulse;
    assign bus.start_stop   = start_stop;
    assign bus.setup_commit = setup_commit;
    assign bus.display_data = display_data;
    assign bus.blank_mask   = blank_mask;

endmodule
`default_nettype wire

// File: tb/tb_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mode_sequencer
// Description : Randomized self-checking bench for mode_sequencer against a
//               behavioural model of the panel rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_sequencer;
    localparam int DEB   = 4;
    localparam int BLINK = 8;
    localparam int IDLE  = 3;
    // raw rise -> press after 2 sync + DEB count + 1 flip edges, FSM reacts one edge later
    localparam int ACT_LAT = 2 + DEB + 1 + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int   n_inc = 0, n_ss = 0, n_commit = 0, n_b2b = 0;
    logic prev_inc = 1'b0, prev_ss = 1'b0, prev_commit = 1'b0;

    logic [1:0]  m_rez = 2'd0;
    logic [1:0]  m_field = 2'd0;
    int          m_idle = 0;
    int          e_inc = 0, e_ss = 0, e_commit = 0;
    logic [23:0] data [4];

    mode_sequencer_if bus ();

    mode_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_HALF     (BLINK),
        .IDLE_TIMEOUT   (IDLE)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.inc_pulse === 1'b1)    n_inc    <= n_inc + 1;
        if (bus.start_stop === 1'b1)   n_ss     <= n_ss + 1;
        if (bus.setup_commit === 1'b1) n_commit <= n_commit + 1;
        if ((bus.inc_pulse === 1'b1 && prev_inc) || (bus.start_stop === 1'b1 && prev_ss) ||
            (bus.setup_commit === 1'b1 && prev_commit))
            n_b2b <= n_b2b + 1;
        prev_inc    <= (bus.inc_pulse === 1'b1);
        prev_ss     <= (bus.start_stop === 1'b1);
        prev_commit <= (bus.setup_commit === 1'b1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_data();
        bus.clock_data     = data[0];
        bus.timer_data     = data[1];
        bus.alarm_data     = data[2];
        bus.stopwatch_data = data[3];
    endtask

    task automatic model_reset();
        m_rez = 2'd0; m_field = 2'd0; m_idle = 0;
    endtask

    task automatic model_press(input int b);
        if (m_field == 2'd0) begin
            case (b)
                0: m_rez = m_rez + 2'd1;
                2: if (m_rez != 2'd3) begin m_field = 2'd1; m_idle = 0; end
                3: if (m_rez == 2'd1 || m_rez == 2'd3) e_ss++;
                default: ;
            endcase
        end else begin
            case (b)
                1: begin e_inc++; m_idle = 0; end
                2: begin
                    m_idle = 0;
                    if (m_field == 2'd3) begin m_field = 2'd0; e_commit++; end
                    else m_field = m_field + 2'd1;
                end
                3: begin m_field = 2'd0; e_commit++; m_idle = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic model_tick();
        if (m_field != 2'd0) begin
            m_idle++;
            if (m_idle == IDLE) begin m_field = 2'd0; m_idle = 0; end
        end
    endtask

    task automatic do_press(input logic [3:0] mask);
        bus.button = mask;
        step($urandom_range(5, 8));
        bus.button = 4'b0000;
        step(DEB + 5);
        if (mask[2])      model_press(2);
        else if (mask[3]) model_press(3);
        else if (mask[1]) model_press(1);
        else if (mask[0]) model_press(0);
    endtask

    task automatic do_tick();
        bus.sec_tick = 1'b1;
        step(1);
        bus.sec_tick = 1'b0;
        step(1);
        model_tick();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step(3);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic goto_rezhim(input logic [1:0] target);
        int guard = 0;
        while (m_rez != target && guard < 4) begin
            do_press(4'b0001);
            guard++;
        end
    endtask

    task automatic test_reset();
        bus.button = 4'b0001;
        reset = 1'b0;
        step(3);
        checks++;
        if ({bus.rezhim, bus.setup_field, bus.inc_pulse, bus.start_stop, bus.setup_commit,
             bus.blank_mask} !== 10'd0 || bus.display_data !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs: rezhim=%h field=%h strobes=%b%b%b blank=%h disp=%h, required all 0",
                     bus.rezhim, bus.setup_field, bus.inc_pulse, bus.start_stop,
                     bus.setup_commit, bus.blank_mask, bus.display_data);
        end
        reset = 1'b1;
        model_reset();
        step(ACT_LAT - 1);
        checks++;
        if (bus.rezhim !== 2'd0) begin
            errors++;
            $display("FAIL held_reset_early: rezhim=%h required 0", bus.rezhim);
        end
        step(1);
        model_press(0);
        checks++;
        if (bus.rezhim !== m_rez) begin
            errors++;
            $display("FAIL held_reset_press: rezhim=%h required %h", bus.rezhim, m_rez);
        end
        bus.button = 4'b0000;
        step(DEB + 8);
        checks++;
        if (bus.rezhim !== m_rez) begin
            errors++;
            $display("FAIL held_reset_single: rezhim=%h required %h", bus.rezhim, m_rez);
        end
    endtask

    task automatic test_debounce();
        apply_reset();
        for (int g = 0; g < 3; g++) begin
            bus.button = 4'b0001;
            step($urandom_range(1, DEB - 1));
            bus.button = 4'b0000;
            step(DEB + 5);
            checks++;
            if (bus.rezhim !== 2'd0) begin
                errors++;
                $display("FAIL glitch_%0d: rezhim=%h required 0", g, bus.rezhim);
            end
        end
        bus.button = 4'b0001;
        step(ACT_LAT - 1);
        checks++;
        if (bus.rezhim !== 2'd0) begin
            errors++;
            $display("FAIL latency_early: rezhim=%h required 0", bus.rezhim);
        end
        step(1);
        checks++;
        if (bus.rezhim !== 2'd1) begin
            errors++;
            $display("FAIL latency_exact: rezhim=%h required 1", bus.rezhim);
        end
        step(10 - ACT_LAT);
        bus.button = 4'b0000;
        step(DEB + 5);
        model_press(0);
    endtask

    task automatic test_mode();
        logic [23:0] old_word;
        for (int i = 0; i < 4; i++) data[i] = 24'($urandom);
        data[1] = 24'h01_02_03;
        drive_data();
        for (int i = 0; i < 4 + int'($urandom_range(0, 3)); i++) begin
            do_press(4'b0001);
            checks++;
            if (bus.rezhim !== m_rez || bus.display_data !== data[m_rez]) begin
                errors++;
                $display("FAIL mode_step_%0d: rezhim=%h disp=%h required %h/%h",
                         i, bus.rezhim, bus.display_data, m_rez, data[m_rez]);
            end
        end
        old_word = data[m_rez];
        data[m_rez] = ~old_word;
        drive_data();
        #1;
        checks++;
        if (bus.display_data !== old_word) begin
            errors++;
            $display("FAIL display_lag_hold: disp=%h required %h", bus.display_data, old_word);
        end
        step(1);
        checks++;
        if (bus.display_data !== data[m_rez]) begin
            errors++;
            $display("FAIL display_lag_update: disp=%h required %h", bus.display_data, data[m_rez]);
        end
    endtask

    task automatic test_setup();
        int inc0, com0, k;
        goto_rezhim(2'd1);
        inc0 = n_inc; com0 = n_commit;
        do_press(4'b0100);
        checks++;
        if (bus.setup_field !== 2'd1) begin
            errors++;
            $display("FAIL setup_enter: field=%h required 1", bus.setup_field);
        end
        k = $urandom_range(2, 4);
        for (int i = 0; i < k; i++) do_press(4'b0010);
        checks++;
        if (n_inc - inc0 !== k || bus.setup_field !== 2'd1) begin
            errors++;
            $display("FAIL setup_inc: incs=%0d field=%h required %0d/1", n_inc - inc0, bus.setup_field, k);
        end
        do_press(4'b0100);
        do_press(4'b0001);
        checks++;
        if (bus.setup_field !== 2'd2 || bus.rezhim !== 2'd1) begin
            errors++;
            $display("FAIL setup_min_frozen: field=%h rezhim=%h required 2/1", bus.setup_field, bus.rezhim);
        end
        do_press(4'b0100);
        checks++;
        if (bus.setup_field !== 2'd3) begin
            errors++;
            $display("FAIL setup_hour: field=%h required 3", bus.setup_field);
        end
        do_press(4'b0100);
        checks++;
        if (bus.setup_field !== 2'd0 || n_commit - com0 !== 1) begin
            errors++;
            $display("FAIL setup_commit: field=%h commits=%0d required 0/1", bus.setup_field, n_commit - com0);
        end
    endtask

    task automatic test_start();
        logic [1:0] order [4];
        int ss0, exp_n;
        order[0] = 2'd3; order[1] = 2'd0; order[2] = 2'd1; order[3] = 2'd2;
        for (int i = 0; i < 4; i++) begin
            goto_rezhim(order[i]);
            if (order[i] == 2'd3) begin
                do_press(4'b0100);
                checks++;
                if (bus.setup_field !== 2'd0) begin
                    errors++;
                    $display("FAIL stopwatch_setup: field=%h required 0", bus.setup_field);
                end
            end
            ss0 = n_ss;
            exp_n = (order[i] == 2'd1 || order[i] == 2'd3) ? 1 : 0;
            do_press(4'b1000);
            checks++;
            if (n_ss - ss0 !== exp_n) begin
                errors++;
                $display("FAIL start_rezhim_%0d: start_stops=%0d required %0d", order[i], n_ss - ss0, exp_n);
            end
        end
    endtask

    task automatic test_timeout_blink();
        int waited = 0;
        int com0;
        logic [2:0] exp_mask;
        goto_rezhim(2'd0);
        com0 = n_commit;
        bus.button = 4'b0100;
        while (bus.setup_field !== 2'd1 && waited < 20) begin
            step(1);
            waited++;
        end
        model_press(2);
        checks++;
        if (bus.setup_field !== 2'd1) begin
            errors++;
            $display("FAIL timeout_entry: field=%h required 1 within 20 cycles", bus.setup_field);
        end
        bus.button = 4'b0000;
        for (int k = 0; k < 3 * BLINK; k++) begin
            exp_mask = {2'b00, 1'((k / BLINK) % 2)};
            checks++;
            if (bus.blank_mask !== exp_mask) begin
                errors++;
                $display("FAIL blink_cycle_%0d: blank=%b required %b", k, bus.blank_mask, exp_mask);
            end
            step(1);
        end
        step(DEB + 5);
        for (int t = 0; t < IDLE - 1; t++) begin
            do_tick();
            checks++;
            if (bus.setup_field !== 2'd1) begin
                errors++;
                $display("FAIL timeout_tick_%0d: field=%h required 1", t, bus.setup_field);
            end
        end
        bus.sec_tick = 1'b1;
        step(1);
        bus.sec_tick = 1'b0;
        model_tick();
        checks++;
        if (bus.setup_field !== 2'd0 || bus.blank_mask !== 3'b000) begin
            errors++;
            $display("FAIL timeout_abort: field=%h blank=%b required 0/000", bus.setup_field, bus.blank_mask);
        end
        step(2);
        checks++;
        if (n_commit - com0 !== 0) begin
            errors++;
            $display("FAIL timeout_no_commit: commits=%0d required 0", n_commit - com0);
        end
    endtask

    task automatic test_priority();
        int inc0, com0;
        goto_rezhim(2'd2);
        do_press(4'b0100);
        inc0 = n_inc;
        do_press(4'b0110);
        checks++;
        if (bus.setup_field !== 2'd2 || n_inc - inc0 !== 0) begin
            errors++;
            $display("FAIL priority_setup_inc: field=%h incs=%0d required 2/0", bus.setup_field, n_inc - inc0);
        end
        com0 = n_commit;
        reset = 1'b0;
        step(1);
        checks++;
        if ({bus.rezhim, bus.setup_field, bus.inc_pulse, bus.start_stop, bus.setup_commit,
             bus.blank_mask} !== 10'd0 || bus.display_data !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_setup: rezhim=%h field=%h blank=%b disp=%h required all 0",
                     bus.rezhim, bus.setup_field, bus.blank_mask, bus.display_data);
        end
        reset = 1'b1;
        model_reset();
        step(3);
        checks++;
        if (n_commit - com0 !== 0 || bus.setup_field !== 2'd0) begin
            errors++;
            $display("FAIL reset_no_commit: commits=%0d field=%h required 0/0", n_commit - com0, bus.setup_field);
        end
    endtask

    task automatic test_random();
        int op;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 5);
            if (op >= 4) do_tick();
            else do_press(4'(1 << op));
            if (($urandom_range(0, 3)) == 0) begin
                data[$urandom_range(0, 3)] = 24'($urandom);
                drive_data();
                step(2);
            end
            checks++;
            if (bus.rezhim !== m_rez || bus.setup_field !== m_field || n_inc !== e_inc ||
                n_ss !== e_ss || n_commit !== e_commit || bus.display_data !== data[m_rez]) begin
                errors++;
                $display("FAIL random_op_%0d: rez=%h fld=%h inc=%0d ss=%0d com=%0d disp=%h required %h %h %0d %0d %0d %h",
                         n, bus.rezhim, bus.setup_field, n_inc, n_ss, n_commit, bus.display_data,
                         m_rez, m_field, e_inc, e_ss, e_commit, data[m_rez]);
            end
        end
    endtask

    task automatic test_back_to_back();
        checks++;
        if (n_b2b !== 0) begin
            errors++;
            $display("FAIL strobe_back_to_back: repeats=%0d required 0", n_b2b);
        end
        checks++;
        if (n_inc !== e_inc || n_ss !== e_ss || n_commit !== e_commit) begin
            errors++;
            $display("FAIL strobe_totals: %0d/%0d/%0d required %0d/%0d/%0d",
                     n_inc, n_ss, n_commit, e_inc, e_ss, e_commit);
        end
    endtask

    initial begin
        bus.button   = 4'b0000;
        bus.sec_tick = 1'b0;
        for (int i = 0; i < 4; i++) data[i] = 24'($urandom);
        drive_data();
        test_reset();
        test_debounce();
        test_mode();
        test_setup();
        test_start();
        test_timeout_blink();
        test_priority();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
